// File: rtl/xor8_pkg.sv
// Shared types and constants for the xor8 checksum stage.
package xor8_pkg;

  localparam int unsigned XOR8_DW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StHold
  } xor8_cksum_state_t;

endpackage

// File: rtl/xor8_cksum_acc.sv
// Running XOR accumulator and saturating byte counter with sticky overflow.
// load starts a new packet with the given byte; step folds in another byte.
module xor8_cksum_acc
  import xor8_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [XOR8_DW-1:0] data,
  output logic [XOR8_DW-1:0] acc_next,
  output logic [LEN_W-1:0]   cnt_next,
  output logic               ovf_next
);

  localparam logic [LEN_W-1:0] CntMax = '1;

  logic [XOR8_DW-1:0] acc_q;
  logic [LEN_W-1:0]   cnt_q;
  logic               ovf_q;

  always_comb begin
    acc_next = acc_q;
    cnt_next = cnt_q;
    ovf_next = ovf_q;
    if (load) begin
      acc_next = data;
      cnt_next = LEN_W'(1);
      ovf_next = 1'b0;
    end else if (step) begin
      acc_next = acc_q ^ data;
      // Counter pins at max; the overflow flag records that bytes were dropped from the count.
      if (cnt_q == CntMax) begin
        ovf_next = 1'b1;
      end else begin
        cnt_next = cnt_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_next;
      cnt_q <= cnt_next;
      ovf_q <= ovf_next;
    end
  end

endmodule

// File: rtl/xor8_pkt_checksum.sv
// Per-packet XOR checksum and length stage with valid/ready on both sides.
// Define XOR8_CKSUM_PARITY_EN to add the out_par (even parity of out_cksum) output.
module xor8_pkt_checksum
  import xor8_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [XOR8_DW-1:0] in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [XOR8_DW-1:0] out_cksum,
  output logic [LEN_W-1:0]   out_len,
  output logic               out_ovf,
  output logic               out_valid,
`ifdef XOR8_CKSUM_PARITY_EN
  output logic               out_par,
`endif
  input  logic               out_ready
);

  xor8_cksum_state_t state_q;

  logic               acc_in;
  logic               acc_out;
  logic               load;
  logic               step;
  logic [XOR8_DW-1:0] acc_next;
  logic [LEN_W-1:0]   cnt_next;
  logic               ovf_next;

  // In HOLD the stage only takes a beat when the result leaves in the same cycle.
  always_comb begin
    in_ready = (state_q == StHold) ? out_ready : 1'b1;
    acc_in   = in_valid & in_ready;
    acc_out  = out_valid & out_ready;
    load     = acc_in & (state_q != StAcc);
    step     = acc_in & (state_q == StAcc);
  end

  xor8_cksum_acc #(
    .LEN_W(LEN_W)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .data    (in_data),
    .acc_next(acc_next),
    .cnt_next(cnt_next),
    .ovf_next(ovf_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      out_cksum <= '0;
      out_len   <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
`ifdef XOR8_CKSUM_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else begin
      if (state_q == StHold && acc_out && !acc_in) begin
        out_valid <= 1'b0;
        state_q   <= StIdle;
      end else if (acc_in && in_last) begin
        out_cksum <= acc_next;
        out_len   <= cnt_next;
        out_ovf   <= ovf_next;
        out_valid <= 1'b1;
`ifdef XOR8_CKSUM_PARITY_EN
        out_par   <= ^acc_next;
`endif
        state_q   <= StHold;
      end else if (acc_in) begin
        out_valid <= 1'b0;
        state_q   <= StAcc;
      end
    end
  end

endmodule

// File: tb/tb_xor8_pkt_checksum.sv
// Scoreboard bench for xor8_pkt_checksum: directed packets plus random traffic and backpressure.
module tb_xor8_pkt_checksum;

  localparam int LEN_W = 3;
  localparam int MAXC  = (1 << LEN_W) - 1;

  typedef logic [7:0] byte_q_t[$];

  typedef struct packed {
    logic [7:0]       cksum;
    logic [LEN_W-1:0] len;
    logic             ovf;
    logic             par;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic [7:0]       out_cksum;
  logic [LEN_W-1:0] out_len;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready = 1'b1;
`ifdef XOR8_CKSUM_PARITY_EN
  logic             out_par;
`endif

  res_t exp_q[$];
  int   total = 0;
  int   passed = 0;
  int   ready_mode = 0;

  always #5 clk = ~clk;

  xor8_pkt_checksum #(
    .LEN_W(LEN_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_cksum(out_cksum),
    .out_len  (out_len),
    .out_ovf  (out_ovf),
    .out_valid(out_valid),
`ifdef XOR8_CKSUM_PARITY_EN
    .out_par  (out_par),
`endif
    .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Reference: checksum is the XOR of the bytes, length is the byte count clipped to MAXC.
  function automatic res_t model(input byte_q_t b);
    res_t r;
    int   n;
    n = b.size();
    r.cksum = 8'h00;
    foreach (b[i]) r.cksum = r.cksum ^ b[i];
    r.len = (n > MAXC) ? LEN_W'(MAXC) : LEN_W'(n);
    r.ovf = (n > MAXC);
    r.par = ^r.cksum;
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: compare the head of the queue every cycle the result is shown; pop on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(out_valid), 32'd0);
        end else begin
          check("cksum", 32'(out_cksum), 32'(exp_q[0].cksum));
          check("len", 32'(out_len), 32'(exp_q[0].len));
          check("ovf", 32'(out_ovf), 32'(exp_q[0].ovf));
`ifdef XOR8_CKSUM_PARITY_EN
          check("par", 32'(out_par), 32'(exp_q[0].par));
`endif
          if (out_ready) void'(exp_q.pop_front());
        end
        check("in_ready_hold", 32'(in_ready), 32'(out_ready));
      end else begin
        check("in_ready_idle", 32'(in_ready), 32'd1);
      end
    end
  end

  // Drive beats from posedge+1; a beat is taken if in_ready is high at the following negedge.
  task automatic send_beats(input byte_q_t b, input bit mark_last, input int gap_pct);
    int waited;
    for (int i = 0; i < b.size(); i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = b[i];
      in_last  = mark_last && (i == b.size() - 1);
      waited   = 0;
      while (1) begin
        @(negedge clk);
        if (in_ready) break;
        waited++;
        if (waited > 200) begin
          check("in_ready_timeout", 32'd0, 32'd1);
          in_valid = 1'b0;
          in_last  = 1'b0;
          return;
        end
      end
      if (in_last) begin
        exp_q.push_back(model(b));
        fork
          begin
            @(negedge clk);
            check("latency_valid", 32'(out_valid), 32'd1);
          end
        join_none
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_pkt(input byte_q_t b, input int gap_pct);
    send_beats(b, 1'b1, gap_pct);
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_cksum", 32'(out_cksum), 32'd0);
    check("rst_len", 32'(out_len), 32'd0);
    check("rst_ovf", 32'(out_ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef XOR8_CKSUM_PARITY_EN
    check("rst_par", 32'(out_par), 32'd0);
`endif
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    check_reset_state();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    byte_q_t pkt;
    int      waited;

    apply_reset();

    // Partial packet discarded by reset, then a single-byte packet.
    pkt = '{8'h11, 8'h22};
    send_beats(pkt, 1'b0, 0);
    apply_reset();
    idle(3);
    pkt = '{8'h05};
    send_pkt(pkt, 0);
    idle(3);

    // Basic four-byte packet.
    pkt = '{8'h01, 8'h02, 8'h04, 8'h08};
    send_pkt(pkt, 0);
    idle(3);

    // Held result under backpressure.
    ready_mode = 2;
    idle(2);
    send_pkt(pkt, 0);
    idle(6);
    ready_mode = 0;
    idle(3);

    // Back-to-back packets with no gap.
    pkt = '{8'hAA, 8'h55};
    send_pkt(pkt, 0);
    pkt = '{8'hFF};
    send_pkt(pkt, 0);
    idle(3);

    // Length saturation and overflow, then overflow cleared by the next packet.
    pkt = {};
    for (int i = 0; i < 9; i++) pkt.push_back(8'h01);
    send_pkt(pkt, 0);
    pkt = '{8'h02};
    send_pkt(pkt, 0);
    idle(3);

    // Parity cases.
    pkt = '{8'h07};
    send_pkt(pkt, 0);
    pkt = '{8'h03};
    send_pkt(pkt, 0);
    idle(3);

    // Random traffic with random consumer backpressure.
    ready_mode = 1;
    for (int p = 0; p < 40; p++) begin
      pkt = {};
      for (int i = 0; i < $urandom_range(1, 12); i++) pkt.push_back(8'($urandom));
      send_pkt(pkt, 25);
    end

    ready_mode = 0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    idle(2);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
